mem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares a single-port synchronous memory (registered read data, one-cycle read latency, synchronous write) between two clients. It accepts one request at a time over a valid/ready handshake, sequences the memory's write_en/read_en/address/w_data, captures r_data, and returns a one-cycle response pulse to the requester that issued the command. It sits directly in front of the memory instance; the memory's own reset is driven separately.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// One command in flight at a time; responses are single-cycle pulses to the issuing requester.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_w_data,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    last_grant_r;
  logic                    owner_r;
  logic                    write_r;
  logic                    grant_idx_s;
  logic [1:0]              grant_s;
  logic                    accept_s;
  logic [1:0]              rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    mem_write_en_r;
  logic                    mem_read_en_r;
  logic [ADDR_WIDTH-1:0]   mem_address_r;
  logic [DATA_WIDTH-1:0]   mem_w_data_r;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic                    sel_write_s;

  function automatic logic [1:0] one_hot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Grant selection (IDLE only) and next-state decode
  always_comb begin
    grant_idx_s  = 1'b0;
    grant_s      = 2'b00;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid == 2'b11) begin
          grant_idx_s = ~last_grant_r;
          grant_s     = one_hot(~last_grant_r);
        end else if (req_valid[0]) begin
          grant_idx_s = 1'b0;
          grant_s     = 2'b01;
        end else if (req_valid[1]) begin
          grant_idx_s = 1'b1;
          grant_s     = 2'b10;
        end else begin
          grant_idx_s = 1'b0;
          grant_s     = 2'b00;
        end
        if (req_valid != 2'b00) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (write_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      WAIT:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  assign accept_s    = |grant_s;
  assign sel_addr_s  = grant_idx_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata_s = grant_idx_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign sel_write_s = grant_idx_s ? req_write[1] : req_write[0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command capture on handshake; memory strobes live for the ISSUE cycle only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r   <= 1'b1;
      owner_r        <= 1'b0;
      write_r        <= 1'b0;
      mem_write_en_r <= 1'b0;
      mem_read_en_r  <= 1'b0;
      mem_address_r  <= {ADDR_WIDTH{1'b0}};
      mem_w_data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      mem_write_en_r <= 1'b0;
      mem_read_en_r  <= 1'b0;
      if (accept_s) begin
        last_grant_r   <= grant_idx_s;
        owner_r        <= grant_idx_s;
        write_r        <= sel_write_s;
        mem_write_en_r <= sel_write_s;
        mem_read_en_r  <= ~sel_write_s;
        mem_address_r  <= sel_addr_s;
        mem_w_data_r   <= sel_wdata_s;
      end
    end
  end

  // Completion pulse; read data is captured only when a read finishes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 2'b00;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp_valid_r <= 2'b00;
      case (state_r)
        ISSUE: begin
          if (write_r) begin
            rsp_valid_r <= one_hot(owner_r);
          end
        end
        WAIT: begin
          rsp_valid_r <= one_hot(owner_r);
          rsp_rdata_r <= mem_r_data;
        end
        default: rsp_valid_r <= 2'b00;
      endcase
    end
  end

  assign req_ready    = grant_s;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign mem_write_en = mem_write_en_r;
  assign mem_read_en  = mem_read_en_r;
  assign mem_address  = mem_address_r;
  assign mem_w_data   = mem_w_data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level model (idle time, response cycle, memory image, round-robin pointer).
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_reset;
  logic [1:0] req_valid, req_write, req_addr_lo, req_addr_hi;
  logic [3:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata, mem_w_data, mem_r_data;
  logic       mem_write_en, mem_read_en;
  logic [1:0] mem_address;

  // requester intents
  logic       rv [2];
  logic       rw [2];
  logic [1:0] ra [2];
  logic [7:0] rd [2];

  assign req_valid = {rv[1], rv[0]};
  assign req_write = {rw[1], rw[0]};
  assign req_addr  = {ra[1], ra[0]};
  assign req_wdata = {rd[1], rd[0]};

  mem_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_address(mem_address), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  // Single-port memory stub: registered read, synchronous write, reset fills 0xFF
  logic [7:0] mem_arr [4];
  always @(posedge clk) begin
    if (mem_reset) begin
      for (int k = 0; k < 4; k++) mem_arr[k] <= 8'hFF;
      mem_r_data <= 8'h00;
    end else begin
      if (mem_write_en) mem_arr[mem_address] <= mem_w_data;
      if (mem_read_en) mem_r_data <= mem_arr[mem_address];
    end
  end

  // reference model
  int         total = 0, bad = 0;
  int         cyc, free_cyc, rsp_cyc, issue_cyc, last_m;
  logic [1:0] rsp_oh;
  logic       rsp_rd, issue_w;
  logic [7:0] rsp_data_m, rdata_m, wdata_m;
  logic [1:0] addr_m;
  logic [7:0] ref_mem [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_cyc = cyc; rsp_cyc = -1; issue_cyc = -1; last_m = 1;
    addr_m = 2'd0; wdata_m = 8'h00; rdata_m = 8'h00; rsp_rd = 1'b0; issue_w = 1'b0;
    rsp_oh = 2'b00; rsp_data_m = 8'h00;
  endtask

  task automatic req(input int i, input logic w, input logic [1:0] a, input logic [7:0] d);
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; rd[i] = d;
  endtask

  // One clock cycle: check outputs at negedge, then apply the handshake at the edge.
  task automatic step(output int g);
    logic [1:0] exp_ready;
    @(negedge clk);
    g = -1;
    if (cyc >= free_cyc) begin
      if (rv[0] && rv[1]) g = (last_m == 1) ? 0 : 1;
      else if (rv[0]) g = 0;
      else if (rv[1]) g = 1;
    end
    exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    if (cyc == rsp_cyc && rsp_rd) rdata_m = rsp_data_m;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'((cyc == rsp_cyc) ? rsp_oh : 2'b00));
    check("rsp_rdata", 32'(rsp_rdata), 32'(rdata_m));
    check("mem_write_en", 32'(mem_write_en), 32'(cyc == issue_cyc && issue_w));
    check("mem_read_en", 32'(mem_read_en), 32'(cyc == issue_cyc && !issue_w));
    check("mem_address", 32'(mem_address), 32'(addr_m));
    check("mem_w_data", 32'(mem_w_data), 32'(wdata_m));
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      addr_m = ra[g]; wdata_m = rd[g]; issue_w = rw[g]; issue_cyc = cyc;
      last_m = g; rsp_oh = (g == 0) ? 2'b01 : 2'b10; rsp_rd = !rw[g];
      if (rw[g]) begin
        ref_mem[ra[g]] = rd[g];
        rsp_cyc = cyc + 1;
      end else begin
        rsp_data_m = ref_mem[ra[g]];
        rsp_cyc = cyc + 2;
      end
      free_cyc = rsp_cyc;
      rv[g] = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    int n = 0;
    while ((rv[0] || rv[1] || cyc <= rsp_cyc || cyc < free_cyc) && n < 60) begin
      step(g);
      n++;
    end
    check("drain_bound", 32'(n < 60), 32'd1);
  endtask

  initial begin
    int g;
    int k;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 2'd0; rd[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
    cyc = 0;
    model_reset();
    reset = 1'b1; mem_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; mem_reset = 1'b0;

    // reset state
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    // requester 0 reads reset contents of addr 2
    req(0, 1'b0, 2'd2, 8'h00);
    drain();
    check("read_ff", 32'(rsp_rdata), 32'hFF);

    // requester 1 writes then reads back addr 3
    req(1, 1'b1, 2'd3, 8'hA5);
    drain();
    req(1, 1'b0, 2'd3, 8'h00);
    drain();
    check("read_a5", 32'(rsp_rdata), 32'hA5);

    // both valid continuously: strict alternation starting with 0, one accept per 3 cycles
    req(0, 1'b0, 2'd0, 8'h00);
    req(1, 1'b0, 2'd1, 8'h00);
    k = 0;
    for (int n = 0; n < 12; n++) begin
      step(g);
      if (g >= 0) begin
        check("rr_order", 32'(g), 32'(k % 2));
        k++;
        req(g, 1'b0, 2'($urandom_range(0, 3)), 8'h00);
      end
    end
    check("rr_accepts", 32'(k), 32'd4);
    rv[0] = 1'b0; rv[1] = 1'b0;
    drain();

    // requester 1 raises valid while requester 0's read is in flight
    req(0, 1'b0, 2'd1, 8'h00);
    step(g);
    req(1, 1'b0, 2'd2, 8'h00);
    step(g);
    step(g);
    step(g);
    check("late_grant", 32'(g), 32'd1);
    drain();

    // reset asserted during WAIT drops the read
    req(0, 1'b0, 2'd1, 8'h00);
    step(g);
    step(g);
    reset = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("midrst_mem_rd", 32'(mem_read_en), 32'd0);
    check("midrst_mem_wr", 32'(mem_write_en), 32'd0);
    check("midrst_mem_addr", 32'(mem_address), 32'd0);
    check("midrst_mem_wdata", 32'(mem_w_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    model_reset();
    req(0, 1'b0, 2'd2, 8'h00);
    req(1, 1'b1, 2'd2, 8'h77);
    step(g);
    check("tie_after_reset", 32'(g), 32'd0);
    drain();

    // write then immediate read of the same word by the other requester
    req(0, 1'b1, 2'd0, 8'h3C);
    req(1, 1'b0, 2'd0, 8'h00);
    drain();
    check("wr_then_rd", 32'(rsp_rdata), 32'h3C);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && ($urandom_range(0, 2) == 0))
          req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
      step(g);
    end
    rv[0] = 1'b0; rv[1] = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
